// File: rtl/md_sched.sv
// Multiply/divide latency scheduler: tracks the HI/LO unit busy window,
// emits the HI/LO commit pulse and the D-stage stall.
//
// Ports:
//   clk             pipeline clock
//   reset           asynchronous active-low reset
//   e_start         E-stage mult/multu/div/divu valid this cycle
//   e_is_div        qualifies e_start: 1 = div/divu, 0 = mult/multu
//   d_md_use        D-stage instruction touches HI/LO or the unit
//   md_busy         unit occupied (md_cnt != 0)
//   md_cnt          remaining busy cycles
//   md_done         one-cycle pulse, HI/LO commit at end of this cycle
//   md_stall        combinational stall to the hazard unit
//   md_err          sticky: start seen while busy
//   md_stall_cycles saturating count of stalled cycles
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_start,
    input  logic              e_is_div,
    input  logic              d_md_use,
    output logic              md_busy,
    output logic [CNT_W-1:0]  md_cnt,
    output logic              md_done,
    output logic              md_stall,
    output logic              md_err,
    output logic [STAT_W-1:0] md_stall_cycles
);

    if (MULT_CYCLES < 1 || MULT_CYCLES > (2**CNT_W) - 1) begin : g_bad_mult
        $error("md_sched: MULT_CYCLES out of range");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > (2**CNT_W) - 1) begin : g_bad_div
        $error("md_sched: DIV_CYCLES out of range");
    end

    localparam logic [CNT_W-1:0]  MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0]  DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              err_q;
    logic [STAT_W-1:0] stat_q;
    logic [STAT_W-1:0] stat_d;

    assign md_busy         = (state_q == S_RUN);
    assign md_cnt          = cnt_q;
    assign md_done         = done_q;
    assign md_err          = err_q;
    assign md_stall_cycles = stat_q;

    // The stall covers the start cycle itself, before the count is loaded.
    assign md_stall = d_md_use & (e_start | md_busy);

    always_comb begin
        stat_d = stat_q;
        if (md_stall && stat_q != STAT_MAX) begin
            stat_d = stat_q + STAT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stat_q  <= '0;
        end else begin
            stat_q <= stat_d;
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    // A start in the done cycle lands here and is legal.
                    if (e_start) begin
                        cnt_q   <= e_is_div ? DIV_LD : MULT_LD;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A start while busy is dropped; only flagged.
                    if (e_start) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == CNT_ONE) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q - CNT_ONE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Testbench for md_sched: vector table, corner-case sequences,
// and randomized traffic against a timestamp-based model.
module tb_md_sched;

    localparam int MC = 5;
    localparam int DC = 10;
    localparam int CW = 4;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          e_start = 1'b0;
    logic          e_is_div = 1'b0;
    logic          d_md_use = 1'b0;
    logic          md_busy;
    logic [CW-1:0] md_cnt;
    logic          md_done;
    logic          md_stall;
    logic          md_err;
    logic [SW-1:0] md_stall_cycles;

    md_sched #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC),
        .CNT_W      (CW),
        .STAT_W     (SW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .e_start        (e_start),
        .e_is_div       (e_is_div),
        .d_md_use       (d_md_use),
        .md_busy        (md_busy),
        .md_cnt         (md_cnt),
        .md_done        (md_done),
        .md_stall       (md_stall),
        .md_err         (md_err),
        .md_stall_cycles(md_stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic st;
        logic dv;
        logic use_;
        int   busy;
        int   cnt;
        int   done;
        int   stall;
        int   err;
        int   sc;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int busy,
                           input int cnt, input int done,
                           input int stall, input int err, input int sc);
        chk({tag, ".busy"}, 32'(md_busy), busy);
        chk({tag, ".cnt"}, 32'(md_cnt), cnt);
        chk({tag, ".done"}, 32'(md_done), done);
        chk({tag, ".stall"}, 32'(md_stall), stall);
        chk({tag, ".err"}, 32'(md_err), err);
        chk({tag, ".sc"}, 32'(md_stall_cycles), sc);
    endtask

    // Cycle boundary: one clock edge later, 1 time unit past the edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic dv, input logic u);
        e_start  = st;
        e_is_div = dv;
        d_md_use = u;
        #1;
    endtask

    // Leaves the bench at drive time of cycle T0 with reset released.
    task automatic do_reset();
        reset    = 1'b0;
        e_start  = 1'b0;
        e_is_div = 1'b0;
        d_md_use = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    int  cyc;
    bit  m_act;
    int  m_start;
    int  m_n;
    bit  m_err;
    int  m_sc;
    bit  m_busy;
    int  e_cnt;
    bit  e_done;
    bit  e_stall;
    logic st_r;
    logic dv_r;
    logic u_r;

    initial begin
        // T0 mult, T6 back-to-back mult in the done cycle, stall probes.
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 5, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 4, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 3, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 2, 0, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 1, 1, 0, 0, 0, 1};
        tbl[6]  = '{1, 0, 1, 0, 0, 1, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 1, 5, 0, 0, 0, 2};
        tbl[8]  = '{0, 0, 0, 1, 4, 0, 0, 0, 2};
        tbl[9]  = '{0, 0, 0, 1, 3, 0, 0, 0, 2};
        tbl[10] = '{0, 0, 0, 1, 2, 0, 0, 0, 2};
        tbl[11] = '{0, 0, 0, 1, 1, 0, 0, 0, 2};
        tbl[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 2};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 2};

        // Reset state
        reset = 1'b0;
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0);

        // Vector table
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].st, tbl[i].dv, tbl[i].use_);
            chk_all($sformatf("tbl[%0d]", i), tbl[i].busy, tbl[i].cnt,
                    tbl[i].done, tbl[i].stall, tbl[i].err, tbl[i].sc);
            next();
        end

        // Asynchronous reset in the middle of a mult
        do_reset();
        drive(1, 0, 0);
        chk_all("rr.T0", 0, 0, 0, 0, 0, 0);
        next();
        drive(0, 0, 1);
        chk_all("rr.T1", 1, 5, 0, 1, 0, 0);
        next();
        drive(0, 0, 0);
        chk_all("rr.T2", 1, 4, 0, 0, 0, 1);
        next();
        drive(0, 0, 0);
        chk_all("rr.T3", 1, 3, 0, 0, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("rr.async", 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0);
            chk_all($sformatf("rr.post%0d", k), 0, 0, 0, 0, 0, 0);
            next();
        end

        // Div with a dependent mflo held in D from T0
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            drive(k == 0, 1, 1);
            chk_all($sformatf("dv.T%0d", k), (k >= 1 && k <= 10),
                    (k >= 1 && k <= 10) ? DC - k + 1 : 0, k == 11,
                    k <= 10, 0, (k < 11) ? k : 11);
            next();
        end

        // Start while busy: ignored, flagged, sticky
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            drive(k == 0 || k == 4, 1, 0);
            chk_all($sformatf("il.T%0d", k), (k >= 1 && k <= 10),
                    (k >= 1 && k <= 10) ? DC - k + 1 : 0, k == 11,
                    0, k >= 5, 0);
            next();
        end

        // Stall statistics saturation
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 1);
            chk($sformatf("sat.T%0d", k), 32'(md_stall_cycles),
                (k < SMAX) ? k : SMAX);
            next();
        end
        drive(0, 0, 0);
        chk("sat.hold", 32'(md_stall_cycles), SMAX);

        // Randomized traffic against a timestamp model
        do_reset();
        m_act = 0;
        m_err = 0;
        m_sc  = 0;
        m_start = 0;
        m_n = 0;
        cyc = 0;
        for (int it = 0; it < 3000; it++) begin
            if (!reset) reset = 1'b1;
            m_busy = m_act && cyc >= m_start + 1 && cyc <= m_start + m_n;
            if ($urandom_range(0, 299) == 0) begin
                e_start  = 1'b0;
                e_is_div = 1'b0;
                d_md_use = 1'b0;
                reset    = 1'b0;
                #1;
                chk_all($sformatf("rnd.rst%0d", it), 0, 0, 0, 0, 0, 0);
                m_act = 0;
                m_err = 0;
                m_sc  = 0;
                next();
                cyc++;
                continue;
            end
            st_r = m_busy ? ($urandom_range(0, 49) == 0)
                          : ($urandom_range(0, 3) == 0);
            dv_r = 1'($urandom_range(0, 1));
            u_r  = ($urandom_range(0, 2) == 0);
            drive(st_r, dv_r, u_r);
            e_cnt   = m_busy ? m_start + m_n - cyc + 1 : 0;
            e_done  = m_act && cyc == m_start + m_n + 1;
            e_stall = u_r && (st_r || m_busy);
            chk_all($sformatf("rnd%0d", it), m_busy, e_cnt, e_done,
                    e_stall, m_err, m_sc);
            if (st_r) begin
                if (m_busy) begin
                    m_err = 1;
                end else begin
                    m_act   = 1;
                    m_start = cyc;
                    m_n     = dv_r ? DC : MC;
                end
            end
            if (e_stall && m_sc < SMAX) m_sc++;
            next();
            cyc++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
